// File: rtl/wb_stream_dma.sv
// rtl/wb_stream_dma.sv - CSR-programmed DMA draining a word stream into Wishbone writes
// Optional ring mode (CTRL bit2) is built when WB_STREAM_DMA_RING_EN is defined.
module wb_stream_dma #(
    parameter logic [3:0] csr_addr        = 4'h0,
    parameter int         fifo_depth_log2 = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        irq,
    input  logic [31:0] stream_dat_i,
    input  logic        stream_stb_i,
    output logic        stream_ack_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic [2:0]  wb_cti_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    input  logic        wb_ack_i
);
    localparam int aw = fifo_depth_log2;
    localparam logic [aw:0] fifo_full_cnt = (aw+1)'(1) << aw;

    typedef enum logic [1:0] {st_idle, st_run, st_wait} state_t;

    state_t      state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] length_q, length_d;
    logic [31:0] count_q, count_d;
    logic        irq_en_q, irq_en_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic        abort_q, abort_d;
    logic        irq_q, irq_d;
    logic [31:0] csr_do_q, csr_do_d;
    logic [31:0] wb_adr_q, wb_adr_d;
    logic [31:0] wb_dat_q, wb_dat_d;
    logic        wb_cyc_q, wb_cyc_d;
    logic [aw-1:0] wr_ptr_q, wr_ptr_d;
    logic [aw-1:0] rd_ptr_q, rd_ptr_d;
    logic [aw:0]   fifo_cnt_q, fifo_cnt_d;
    logic [31:0]   mem_q [1 << aw];

    logic        ring_on;
`ifdef WB_STREAM_DMA_RING_EN
    logic        ring_q, ring_d;
    assign ring_on = ring_q;
`else
    assign ring_on = 1'b0;
`endif

    logic        csr_sel, wr_base, wr_len, wr_ctrl, wr_stat;
    logic        busy, fifo_full, fifo_empty, push, pop, start, abort_req, at_len, flush;
    logic [31:0] count_inc;
    logic        unused_csr_bits;

    assign unused_csr_bits = &{1'b0, csr_a[9:3]};

    assign csr_sel = (csr_a[13:10] == csr_addr);
    assign wr_base = csr_sel & csr_we & (csr_a[2:0] == 3'd0);
    assign wr_len  = csr_sel & csr_we & (csr_a[2:0] == 3'd1);
    assign wr_ctrl = csr_sel & csr_we & (csr_a[2:0] == 3'd2);
    assign wr_stat = csr_sel & csr_we & (csr_a[2:0] == 3'd4);

    assign busy       = (state_q != st_idle);
    assign fifo_full  = (fifo_cnt_q == fifo_full_cnt);
    assign fifo_empty = (fifo_cnt_q == '0);
    assign stream_ack_o = busy & ~fifo_full;
    assign push       = stream_stb_i & stream_ack_o;
    assign pop        = (state_q == st_wait) & wb_ack_i;
    assign start      = wr_ctrl & csr_di[0] & ~busy;
    // An abort written in the same cycle as an ack must still be honoured.
    assign abort_req  = abort_q | (wr_ctrl & ~csr_di[0] & busy);
    assign count_inc  = count_q + 32'd1;
    assign at_len     = (count_inc == length_q);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) state_q <= st_idle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            st_idle: if (start && length_q != '0) state_d = st_run;
            st_run: begin
                if (abort_req)        state_d = st_idle;
                else if (!fifo_empty) state_d = st_wait;
            end
            st_wait: begin
                if (wb_ack_i) begin
                    if (at_len)         state_d = (ring_on && !abort_req) ? st_run : st_idle;
                    else if (abort_req) state_d = st_idle;
                    else                state_d = st_run;
                end
            end
            default: state_d = st_idle;
        endcase
    end

    assign flush = busy & (state_d == st_idle);

    always_comb begin
        base_d    = base_q;
        length_d  = length_q;
        count_d   = count_q;
        irq_en_d  = irq_en_q;
        done_d    = done_q;
        aborted_d = aborted_q;
        wb_adr_d  = wb_adr_q;
        wb_dat_d  = wb_dat_q;
        wb_cyc_d  = wb_cyc_q;
`ifdef WB_STREAM_DMA_RING_EN
        ring_d    = ring_q;
        if (wr_ctrl) ring_d = csr_di[2];
`endif
        if (wr_base) base_d   = {csr_di[31:2], 2'b00};
        if (wr_len)  length_d = csr_di;
        if (wr_ctrl) irq_en_d = csr_di[1];
        if (wr_stat) begin
            if (csr_di[0]) done_d    = 1'b0;
            if (csr_di[1]) aborted_d = 1'b0;
        end
        irq_d   = done_q & irq_en_q;
        abort_d = abort_req & (state_d != st_idle);

        case (state_q)
            st_idle: begin
                if (start) begin
                    if (length_q != '0) count_d = '0;
                    else                done_d  = 1'b1;
                end
            end
            st_run: begin
                if (!abort_req && !fifo_empty) begin
                    wb_adr_d = base_q + {count_q[29:0], 2'b00};
                    wb_dat_d = mem_q[rd_ptr_q];
                    wb_cyc_d = 1'b1;
                end
            end
            st_wait: begin
                if (wb_ack_i) begin
                    wb_cyc_d = 1'b0;
                    count_d  = (at_len && ring_on) ? '0 : count_inc;
                    if (at_len) done_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (flush && abort_req) aborted_d = 1'b1;

        if (flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end else begin
            wr_ptr_d   = wr_ptr_q + aw'(push);
            rd_ptr_d   = rd_ptr_q + aw'(pop);
            fifo_cnt_d = fifo_cnt_q + (aw+1)'(push) - (aw+1)'(pop);
        end

        csr_do_d = '0;
        if (csr_sel) begin
            case (csr_a[2:0])
                3'd0:    csr_do_d = base_q;
                3'd1:    csr_do_d = length_q;
                3'd2:    csr_do_d = {29'd0, ring_on, irq_en_q, busy};
                3'd3:    csr_do_d = count_q;
                3'd4:    csr_do_d = {30'd0, aborted_q, done_q};
                default: csr_do_d = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push) mem_q[wr_ptr_q] <= stream_dat_i;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            base_q     <= '0;
            length_q   <= '0;
            count_q    <= '0;
            irq_en_q   <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            abort_q    <= 1'b0;
            irq_q      <= 1'b0;
            csr_do_q   <= '0;
            wb_adr_q   <= '0;
            wb_dat_q   <= '0;
            wb_cyc_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
`ifdef WB_STREAM_DMA_RING_EN
            ring_q     <= 1'b0;
`endif
        end else begin
            base_q     <= base_d;
            length_q   <= length_d;
            count_q    <= count_d;
            irq_en_q   <= irq_en_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            abort_q    <= abort_d;
            irq_q      <= irq_d;
            csr_do_q   <= csr_do_d;
            wb_adr_q   <= wb_adr_d;
            wb_dat_q   <= wb_dat_d;
            wb_cyc_q   <= wb_cyc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
`ifdef WB_STREAM_DMA_RING_EN
            ring_q     <= ring_d;
`endif
        end
    end

    assign csr_do   = csr_do_q;
    assign irq      = irq_q;
    assign wb_adr_o = wb_adr_q;
    assign wb_dat_o = wb_dat_q;
    assign wb_cyc_o = wb_cyc_q;
    assign wb_stb_o = wb_cyc_q;
    assign wb_sel_o = 4'hf;
    assign wb_we_o  = 1'b1;
    assign wb_cti_o = 3'b000;
endmodule

// File: tb/tb_wb_stream_dma.sv
// tb/tb_wb_stream_dma.sv - randomized self-checking bench for wb_stream_dma
module tb_wb_stream_dma;
    logic        sys_clk, sys_rst;
    logic [13:0] csr_a;
    logic        csr_we;
    logic [31:0] csr_di, csr_do;
    logic        irq;
    logic [31:0] stream_dat_i;
    logic        stream_stb_i, stream_ack_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic [2:0]  wb_cti_o;
    logic        wb_cyc_o, wb_stb_o, wb_ack_i;

    wb_stream_dma #(.csr_addr(4'h0), .fifo_depth_log2(3)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .csr_a(csr_a), .csr_we(csr_we), .csr_di(csr_di), .csr_do(csr_do), .irq(irq),
        .stream_dat_i(stream_dat_i), .stream_stb_i(stream_stb_i), .stream_ack_o(stream_ack_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_cti_o(wb_cti_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Stream source: offers words from send_q, records every word the DUT takes.
    logic [31:0] send_q[$];
    logic [31:0] accepted[$];
    int          max_gap = 0;
    bit          flush_req = 0;
    initial begin
        int gap;
        bit ack_prev;
        gap = 0;
        ack_prev = 0;
        stream_stb_i = 1'b0;
        stream_dat_i = '0;
        forever begin
            @(posedge sys_clk); #1;
            if (stream_stb_i && ack_prev) begin
                accepted.push_back(stream_dat_i);
                void'(send_q.pop_front());
                stream_stb_i = 1'b0;
                gap = $urandom_range(max_gap, 0);
            end
            if (flush_req) begin
                send_q.delete();
                stream_stb_i = 1'b0;
                flush_req = 0;
            end
            if (!stream_stb_i && send_q.size() > 0) begin
                if (gap == 0) begin
                    stream_stb_i = 1'b1;
                    stream_dat_i = send_q[0];
                end else gap--;
            end
            ack_prev = stream_ack_o;
        end
    end

    // Wishbone slave: acks after a random wait, records every write it acks.
    logic [31:0] obs_adr[$];
    logic [31:0] obs_dat[$];
    int          ack_limit = 1000000;
    int          dly_min = 2, dly_max = 2;
    bit          cyc_seen = 0;
    initial begin
        int wcnt;
        wcnt = 2;
        wb_ack_i = 1'b0;
        forever begin
            @(posedge sys_clk); #2;
            if (wb_cyc_o) cyc_seen = 1;
            if (wb_ack_i) wb_ack_i = 1'b0;
            else if (wb_cyc_o && wb_stb_o && obs_adr.size() < ack_limit) begin
                if (wcnt <= 0) begin
                    wb_ack_i = 1'b1;
                    obs_adr.push_back(wb_adr_o);
                    obs_dat.push_back(wb_dat_o);
                    wcnt = $urandom_range(dly_max, dly_min);
                end else wcnt--;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk); #3;
    endtask

    task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
        csr_a = {4'h0, 7'd0, a};
        csr_di = d;
        csr_we = 1'b1;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic csr_rd(input logic [3:0] page, input logic [2:0] a, output logic [31:0] d);
        csr_a = {page, 7'd0, a};
        csr_we = 1'b0;
        tick();
        d = csr_do;
    endtask

    task automatic clear_bench();
        obs_adr.delete();
        obs_dat.delete();
        accepted.delete();
        cyc_seen = 0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] v;
        int n;
        n = 0;
        do begin
            csr_rd(4'h0, 3'd2, v);
            n++;
        end while (v[0] && n < 3000);
        check_eq({tag, " idle"}, 32'(v[0]), 32'd0);
    endtask

    task automatic wait_obs(input string tag, input int n);
        int k;
        k = 0;
        while (obs_adr.size() < n && k < 3000) begin
            tick();
            k++;
        end
        check_eq({tag, " nwrites"}, obs_adr.size(), n);
    endtask

    // Reference: word i of the run lands at BASE + 4*(i mod period), modulo 2^32.
    task automatic check_writes(input string tag, input logic [31:0] base, input int n, input int period);
        logic [31:0] exp_a;
        check_eq({tag, " nwrites"}, obs_adr.size(), n);
        for (int i = 0; i < n && i < obs_adr.size() && i < accepted.size(); i++) begin
            exp_a = (base & 32'hFFFF_FFFC) + 32'(4 * (i % period));
            check_eq($sformatf("%s adr[%0d]", tag, i), obs_adr[i], exp_a);
            check_eq($sformatf("%s dat[%0d]", tag, i), obs_dat[i], accepted[i]);
        end
    endtask

    initial begin
        logic [31:0] v, base, word;
        int len;
        bit ien;
        sys_rst = 1'b1;
        csr_a = '0;
        csr_we = 1'b0;
        csr_di = '0;
        repeat (3) tick();

        check_eq("rst csr_do", csr_do, 0);
        check_eq("rst irq", 32'(irq), 0);
        check_eq("rst stream_ack", 32'(stream_ack_o), 0);
        check_eq("rst cyc", 32'(wb_cyc_o), 0);
        check_eq("rst stb", 32'(wb_stb_o), 0);
        check_eq("rst adr", wb_adr_o, 0);
        check_eq("rst dat", wb_dat_o, 0);
        check_eq("const sel", 32'(wb_sel_o), 32'hf);
        check_eq("const we", 32'(wb_we_o), 1);
        check_eq("const cti", 32'(wb_cti_o), 0);
        sys_rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            csr_rd(4'h0, 3'(a), v);
            check_eq($sformatf("rst reg%0d", a), v, 0);
        end

        // Basic three-word transfer with 2-cycle slave latency.
        clear_bench();
        csr_wr(3'd0, 32'h4000_0100);
        csr_wr(3'd1, 32'd3);
        csr_wr(3'd2, 32'd3);
        send_q.push_back(32'hA);
        send_q.push_back(32'hB);
        send_q.push_back(32'hC);
        wait_idle("t1");
        check_writes("t1", 32'h4000_0100, 3, 3);
        csr_rd(4'h0, 3'd3, v);  check_eq("t1 count", v, 3);
        csr_rd(4'h0, 3'd4, v);  check_eq("t1 status", v, 1);
        check_eq("t1 irq", 32'(irq), 1);
        csr_rd(4'h1, 3'd1, v);  check_eq("t1 other page", v, 0);
        csr_wr(3'd4, 32'd1);
        csr_rd(4'h0, 3'd4, v);  check_eq("t1 status w1c", v, 0);
        tick();
        check_eq("t1 irq clear", 32'(irq), 0);

        // Randomized runs; the first exercises 32-bit address wrap.
        for (int it = 0; it < 6; it++) begin
            clear_bench();
            base = (it == 0) ? 32'hFFFF_FFFC : $urandom;
            len  = (it == 0) ? 2 : $urandom_range(12, 1);
            ien  = 1'($urandom_range(1, 0));
            dly_min = 0;
            dly_max = $urandom_range(3, 0);
            max_gap = $urandom_range(2, 0);
            csr_wr(3'd0, base);
            csr_rd(4'h0, 3'd0, v);
            check_eq($sformatf("r%0d base", it), v, base & 32'hFFFF_FFFC);
            csr_wr(3'd1, 32'(len));
            csr_wr(3'd2, {30'd0, ien, 1'b1});
            for (int i = 0; i < len; i++) send_q.push_back($urandom);
            wait_idle($sformatf("r%0d", it));
            check_writes($sformatf("r%0d", it), base, len, len);
            csr_rd(4'h0, 3'd3, v);  check_eq($sformatf("r%0d count", it), v, 32'(len));
            csr_rd(4'h0, 3'd4, v);  check_eq($sformatf("r%0d status", it), v, 1);
            check_eq($sformatf("r%0d irq", it), 32'(irq), 32'(ien));
            csr_wr(3'd4, 32'd3);
        end
        max_gap = 0;

        // Zero-length start: DONE only, no bus activity.
        clear_bench();
        csr_wr(3'd1, 32'd0);
        csr_wr(3'd2, 32'd3);
        csr_rd(4'h0, 3'd4, v);  check_eq("z status", v, 1);
        check_eq("z irq", 32'(irq), 1);
        csr_wr(3'd4, 32'd3);
        csr_wr(3'd2, 32'd1);
        csr_rd(4'h0, 3'd4, v);  check_eq("z status noirq", v, 1);
        tick();
        check_eq("z irq off", 32'(irq), 0);
        check_eq("z no cyc", 32'(cyc_seen), 0);
        csr_wr(3'd4, 32'd3);

        // Abort during a stalled fifth cycle.
        clear_bench();
        dly_min = 1;
        dly_max = 1;
        ack_limit = 4;
        base = 32'h0000_1000;
        csr_wr(3'd0, base);
        csr_wr(3'd1, 32'd10);
        csr_wr(3'd2, 32'd1);
        for (int i = 0; i < 10; i++) send_q.push_back($urandom);
        begin
            int k;
            k = 0;
            while (!(obs_adr.size() == 4 && wb_cyc_o) && k < 1000) begin
                tick();
                k++;
            end
        end
        repeat (3) tick();
        check_eq("ab stalled cyc", 32'(wb_cyc_o), 1);
        csr_wr(3'd2, 32'd0);
        ack_limit = 5;
        wait_idle("ab");
        flush_req = 1;
        repeat (2) tick();
        check_writes("ab", base, 5, 10);
        csr_rd(4'h0, 3'd3, v);  check_eq("ab count", v, 5);
        csr_rd(4'h0, 3'd4, v);  check_eq("ab status", v, 2);
        check_eq("ab stream_ack", 32'(stream_ack_o), 0);
        ack_limit = 1000000;
        csr_wr(3'd4, 32'd3);
        clear_bench();
        word = 32'h5A5A_1234;
        csr_wr(3'd1, 32'd1);
        csr_wr(3'd2, 32'd1);
        send_q.push_back(word);
        wait_idle("ab2");
        check_writes("ab2 fifo flushed", base, 1, 1);

        // Slave never acks: backpressure at FIFO depth, then reset mid-cycle.
        csr_wr(3'd4, 32'd3);
        clear_bench();
        ack_limit = 0;
        base = 32'h0000_2000;
        csr_wr(3'd0, base);
        csr_wr(3'd1, 32'd20);
        csr_wr(3'd2, 32'd1);
        for (int i = 0; i < 12; i++) send_q.push_back($urandom);
        repeat (40) tick();
        check_eq("na accepted", accepted.size(), 8);
        check_eq("na stream_ack", 32'(stream_ack_o), 0);
        check_eq("na cyc held", 32'(wb_cyc_o), 1);
        check_eq("na stb held", 32'(wb_stb_o), 1);
        check_eq("na adr", wb_adr_o, base);
        if (accepted.size() > 0) check_eq("na dat", wb_dat_o, accepted[0]);
        flush_req = 1;
        sys_rst = 1'b1;
        tick();
        check_eq("na rst cyc", 32'(wb_cyc_o), 0);
        check_eq("na rst stb", 32'(wb_stb_o), 0);
        sys_rst = 1'b0;
        for (int a = 0; a < 5; a++) begin
            csr_rd(4'h0, 3'(a), v);
            check_eq($sformatf("na reg%0d", a), v, 0);
        end
        ack_limit = 1000000;

`ifdef WB_STREAM_DMA_RING_EN
        clear_bench();
        dly_min = 0;
        dly_max = 2;
        base = 32'h0000_3000;
        csr_wr(3'd0, base);
        csr_wr(3'd1, 32'd2);
        csr_wr(3'd2, 32'd5);
        for (int i = 0; i < 5; i++) send_q.push_back($urandom);
        wait_obs("ring", 5);
        repeat (3) tick();
        check_writes("ring", base, 5, 2);
        csr_rd(4'h0, 3'd4, v);  check_eq("ring status", v, 1);
        csr_rd(4'h0, 3'd2, v);  check_eq("ring ctrl", v, 32'h5);
        csr_rd(4'h0, 3'd3, v);  check_eq("ring count", v, 1);
        csr_wr(3'd2, 32'd0);
        wait_idle("ring");
        csr_rd(4'h0, 3'd4, v);  check_eq("ring abort status", v, 3);
`else
        csr_wr(3'd2, 32'd4);
        csr_rd(4'h0, 3'd2, v);  check_eq("noring ctrl", v, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
